// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage streaming saturating subtractor: diff = clamp(a - b) with valid/ready on both sides.
// Stage 1 holds the exact (WIDTH+1)-bit difference; stage 2 clamps and drives the output register.
module signed_sub_with_saturation_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             sat_pos,
    output logic             sat_neg,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] sat_pos_cnt,
    output logic [CNT_W-1:0] sat_neg_cnt
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid;
    logic [WIDTH:0]   s1_raw;
    logic             s1_a_s;
    logic             s1_b_s;

    logic             s1_adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH:0]   raw_in;

    logic [WIDTH-1:0] diff_next;
    logic             sat_pos_next;
    logic             sat_neg_next;
    logic             ovf;

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // One extra bit keeps the exact difference, so overflow is decided later without re-deriving it.
    assign raw_in = {a[WIDTH-1], a} - {b[WIDTH-1], b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_a_s   <= 1'b0;
            s1_b_s   <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_raw   <= raw_in;
            s1_a_s   <= a[WIDTH-1];
            s1_b_s   <= b[WIDTH-1];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Overflow needs opposite operand signs and a result sign that disagrees with the minuend.
    // The top raw bit is the true sign of the exact difference and picks the clamp direction.
    assign ovf = (s1_a_s != s1_b_s) && (s1_raw[WIDTH-1] != s1_a_s);

    always_comb begin
        diff_next    = s1_raw[WIDTH-1:0];
        sat_pos_next = 1'b0;
        sat_neg_next = 1'b0;
        if (ovf) begin
            if (s1_raw[WIDTH]) begin
                diff_next    = MIN_NEG;
                sat_neg_next = 1'b1;
            end else begin
                diff_next    = MAX_POS;
                sat_pos_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            sat_pos   <= 1'b0;
            sat_neg   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            diff      <= diff_next;
            sat_pos   <= sat_pos_next;
            sat_neg   <= sat_neg_next;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Event counters stick at all-ones; a clear in the same cycle as an event wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_pos_cnt <= '0;
        end else if (cnt_clear) begin
            sat_pos_cnt <= '0;
        end else if (out_xfer && sat_pos && (sat_pos_cnt != CNT_MAX)) begin
            sat_pos_cnt <= sat_pos_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_neg_cnt <= '0;
        end else if (cnt_clear) begin
            sat_neg_cnt <= '0;
        end else if (out_xfer && sat_neg && (sat_neg_cnt != CNT_MAX)) begin
            sat_neg_cnt <= sat_neg_cnt + CNT_W'(1);
        end
    end

endmodule
